// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch-to-decode valid/ready stream interface
interface fetch_stage_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  // fetch side drives the entry, decode side drives ready
  modport master (output out_valid, output out_pc, output out_instr, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instr, output out_ready);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, redirect and fetch buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       imem_pc,
  input  logic [31:0]       imem_instr,
  input  logic              redirect,
  input  logic [31:0]       redirect_target,
  input  logic              halt,
  fetch_stage_if.master     out_if,
  output logic              misaligned_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          err_q;

  logic pop;
  logic can_push;
  logic push;

  // handshake and push decision; a full buffer still accepts when its head leaves
  always_comb begin
    pop      = (count != '0) && out_if.out_ready;
    can_push = (count < CW'(DEPTH)) || pop;
    push     = !redirect && !halt && can_push;
  end

  // memory address and head-of-buffer presentation, NOP when empty
  always_comb begin
    imem_pc          = pc_q;
    misaligned_err   = err_q;
    out_if.out_valid = (count != '0);
    out_if.out_pc    = 32'h0;
    out_if.out_instr = NOP_INSTR;
    if (count != '0) begin
      out_if.out_pc    = pc_mem[rd_ptr];
      out_if.out_instr = instr_mem[rd_ptr];
    end
  end

  // PC, pointers, occupancy and sticky error; redirect flushes everything including a same-cycle pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else if (redirect) begin
      pc_q   <= {redirect_target[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (redirect_target[1:0] != 2'b00) begin
        err_q <= 1'b1;
      end
    end else begin
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // buffer storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem[wr_ptr]    <= pc_q;
      instr_mem[wr_ptr] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a queue-based reference model
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h00000000;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halt = 1'b0;
  logic        misaligned_err;

  fetch_stage_if out_if ();

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_pc         (imem_pc),
    .imem_instr      (imem_instr),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .out_if          (out_if.master),
    .misaligned_err  (misaligned_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign imem_instr = mem_word(imem_pc);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] m_pc;
  logic        m_err;
  bit          started = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // reference model: fetch buffer is a queue holding at most DEPTH entries
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_pc  = RESET_PC;
      m_err = 1'b0;
    end else if (redirect) begin
      exp_q.delete();
      m_pc = redirect_target & 32'hFFFF_FFFC;
      if (redirect_target[1:0] != 2'b00) m_err = 1'b1;
    end else if (!halt && exp_q.size() < DEPTH) begin
      exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    started = 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: compares outputs mid-cycle and retires the head entry on a handshake
  always @(negedge clk) begin
    if (started) begin
      chk("imem_pc", imem_pc, m_pc);
      chk("misaligned_err", {31'b0, misaligned_err}, {31'b0, m_err});
      chk("out_valid", {31'b0, out_if.out_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("out_pc", out_if.out_pc, exp_q[0].pc);
        chk("out_instr", out_if.out_instr, exp_q[0].instr);
        if (out_if.out_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_pc_empty", out_if.out_pc, 32'h0);
        chk("out_instr_empty", out_if.out_instr, NOP_INSTR);
      end
    end
  end

  task automatic cyc(input logic r, input logic rd, input logic [31:0] tgt,
                     input logic h, input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      rst_n           = r;
      redirect        = rd;
      redirect_target = tgt;
      halt            = h;
      out_if.out_ready = rdy;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    out_if.out_ready = 1'b0;
    // reset, then stream
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 10);
    // backpressure, then drain
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4);
    // fill, then redirect with a same-cycle pop
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    cyc(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 5);
    // misaligned redirect
    cyc(1'b1, 1'b1, 32'h0000_0206, 1'b0, 1'b1, 1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 6);
    // address wrap, halt, resume
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4);
    // mid-operation reset with a full buffer and a redirect
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    cyc(1'b0, 1'b1, 32'h0000_0302, 1'b0, 1'b0, 1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, rd, h, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 299) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      h   = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8 | (tgt & 32'h7);
      cyc(r, rd, tgt, h, rdy, 1);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the RISC-V core. It owns the program counter and drives it to the instruction memory, which returns the 32-bit instruction combinationally in the same cycle. It captures each {pc, instruction} pair into a small in-order buffer and presents it to decode over a valid/ready handshake. It also handles branch/jump redirects, which flush the buffer, and a halt input.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
DEPTH, 2, fetch buffer entries; power of two, at least 2
NOP_INSTR, 32'h00000013, value driven on out_instr while the buffer is empty

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  synchronous reset, active-low
imem_pc  out  32  address to instruction memory; always equals the PC register
imem_instr  in  32  instruction from memory for imem_pc, valid in the same cycle
redirect  in  1  branch/jump taken; load redirect_target
redirect_target  in  32  new PC
halt  in  1  suppress new fetches; the buffer still drains
out_valid  out  1  head entry available to decode
out_ready  in  1  decode accepts the head entry
out_pc  out  32  PC of the head entry
out_instr  out  32  instruction of the head entry
misaligned_err  out  1  sticky flag; a redirect_target had bits [1:0] != 0

Behaviour:
- State: pc_q (32 bits), circular buffer of DEPTH {pc, instr} entries, rd_ptr and wr_ptr (log2 DEPTH bits each), count (0..DEPTH), err_q.
- Reset (rst_n=0 at a rising edge):
  - pc_q=RESET_PC; count=0; pointers=0; err_q=0.
  - Resulting outputs: out_valid=0, out_pc=0, out_instr=NOP_INSTR, misaligned_err=0, imem_pc=RESET_PC.
  - Reset overrides redirect, halt and any in-flight handshake. Buffer contents are discarded.
- imem_pc = pc_q, combinational.
- out_valid = (count != 0).
- out_pc and out_instr:
  - count != 0: head entry at rd_ptr, driven straight from storage with no added latency.
  - count == 0: out_pc=0 and out_instr=NOP_INSTR.
- pop = out_valid & out_ready.
- can_push = (count < DEPTH) | pop. A push into a full buffer is allowed when a pop happens in the same cycle.
- push = !redirect & !halt & can_push.
- Per-cycle priority:
  1. redirect=1:
     - pc_q <= {redirect_target[31:2], 2'b00}.
     - count, rd_ptr and wr_ptr <= 0; the flush discards every entry, including one popped this cycle.
     - No push. If redirect_target[1:0] != 0, err_q <= 1.
  2. Otherwise, if push:
     - Write {pc_q, imem_instr} at wr_ptr; wr_ptr++.
     - pc_q <= pc_q + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
  3. Otherwise pc_q holds (halt asserted, or buffer full with no pop).
  - If pop and no redirect: rd_ptr++.
  - count updates by push minus pop when there is no redirect.
  - Pointers wrap modulo DEPTH.
- Latency: an instruction fetched in cycle N is visible on out_* in cycle N+1. Redirect in cycle N means the target instruction appears on out_* in cycle N+2; out_valid is 0 in cycle N+1.
- Throughput: one instruction per cycle while out_ready=1 and there is no halt or redirect.
- Handshake: while out_valid=1 and out_ready=0, out_pc and out_instr stay stable until popped or flushed.
- halt takes effect immediately; redirect while halted still loads pc_q and flushes.
- err_q clears only on reset.

Test Plan:
- Reset then stream: RESET_PC=0, out_ready=1, memory word k = 32'h1000_0000+k. Required: out_valid rises 1 cycle after reset release; out_pc = 0,4,8,... in consecutive cycles with matching instructions; no gaps.
- Backpressure: out_ready=0 for 5 cycles. Required: count saturates at 2; pc_q holds at the PC of entry 3; out_pc stays stable. Then out_ready=1: in-order delivery with no loss or duplicate.
- Redirect while full with a pop in the same cycle: redirect_target=32'h0000_0100. Required: next cycle out_valid=0; the following cycle out_pc=0x100; both old entries are never delivered after the flush.
- Misaligned redirect: target 32'h0000_0206. Required: fetch resumes at 0x204; misaligned_err=1 and stays 1 until rst_n=0.
- Wrap and halt: redirect to 32'hFFFF_FFFC, then 32'hFFFF_FFFC followed by 0 are delivered. Assert halt for 3 cycles: no new entries, the buffer drains, imem_pc frozen. Deassert halt: fetch resumes from the frozen PC.
- Mid-operation reset: rst_n=0 for 1 cycle with buffer full and redirect=1. Required: next cycle out_valid=0, imem_pc=RESET_PC, misaligned_err=0.
